// File: rtl/glob_acc_seq_ctrl_if.sv
// Bundle of configuration, control and strobe signals between the layer-config
// side and the global-accumulator control sequencer.
// The slave modport is the sequencer; the master modport is the config/pipe side.
//
// Handshake rules:
//   start     - one-cycle request. It is taken only while busy is low. busy rises
//               the cycle after acceptance and falls in the cycle done pulses.
//   stall     - level back-pressure with no ready pairing. Any cycle it is high
//               freezes sequencing, and no latch or row-end strobe follows that cycle.
//   pipe_done - one-cycle return pulse per row. It is always accepted and never
//               back-pressured.
interface glob_acc_seq_ctrl_if #(
  parameter int ROW_W = 6,
  parameter int ACC_W = 8,
  parameter int THR_W = 16
);
  // control and configuration
  logic             start;
  logic             cfg_dense;
  logic [ROW_W-1:0] cfg_rows;
  logic [ACC_W-1:0] cfg_acc_len;
  logic [THR_W-1:0] cfg_et_thr;
  logic             stall;
  logic             pipe_done;

  // pipe strobes
  logic [ROW_W-1:0] ROW_INDEX;
  logic             RowIndex_Update;
  logic             BnkCtr_Clr;
  logic             BnkCtr_Latch;
  logic             GlbCtr_Latch;
  logic             MxPl_Sparse_Clr;
  logic             MxPl_Sparse_Latch;
  logic             MxPl_Dense_Clr;
  logic             MxPl_Dense_Latch;
  logic             ET_L1_Clr;
  logic             ET_L1_En;
  logic             ET_L3_En;
  logic             ET_Thr_Latch;
  logic [THR_W-1:0] ET_THRESHOLD;
  logic             busy;
  logic             done;

  // debug visibility of sequencer state and outstanding-row count
  logic [2:0]       state_dbg;
  logic [ROW_W:0]   outstanding_dbg;

  modport master (
    output start, cfg_dense, cfg_rows, cfg_acc_len, cfg_et_thr, stall, pipe_done,
    input  ROW_INDEX, RowIndex_Update, BnkCtr_Clr, BnkCtr_Latch, GlbCtr_Latch,
           MxPl_Sparse_Clr, MxPl_Sparse_Latch, MxPl_Dense_Clr, MxPl_Dense_Latch,
           ET_L1_Clr, ET_L1_En, ET_L3_En, ET_Thr_Latch, ET_THRESHOLD, busy, done,
           state_dbg, outstanding_dbg
  );

  modport slave (
    input  start, cfg_dense, cfg_rows, cfg_acc_len, cfg_et_thr, stall, pipe_done,
    output ROW_INDEX, RowIndex_Update, BnkCtr_Clr, BnkCtr_Latch, GlbCtr_Latch,
           MxPl_Sparse_Clr, MxPl_Sparse_Latch, MxPl_Dense_Clr, MxPl_Dense_Latch,
           ET_L1_Clr, ET_L1_En, ET_L3_En, ET_Thr_Latch, ET_THRESHOLD, busy, done,
           state_dbg, outstanding_dbg
  );
endinterface

// File: rtl/glob_acc_seq_ctrl.sv
// Global-accumulator control sequencer. It issues the per-layer clear,
// accumulate, latch, row-index and early-termination strobes, and it counts
// rows still in flight in the pipe until their compute_done pulses return.
// Optional feature macro: GLACC_SEQ_ET_EN. When this macro is defined, the
// ET strobes and ET_THRESHOLD are generated. When it is not defined, they stay 0.
//
// Every output is registered. The decision taken at a clock edge, from the
// current state and the inputs sampled there, appears on the outputs in the
// next cycle. The state register names the phase whose decision comes next:
// SETUP while the clear strobes are visible, ROW_END while the last latch of
// a row is visible, and so on. This gives start -> first BnkCtr_Latch in two
// cycles, and done one cycle after the final pipe_done.
module glob_acc_seq_ctrl #(
  parameter int ROW_W = 6,
  parameter int ACC_W = 8,
  parameter int THR_W = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  glob_acc_seq_ctrl_if.slave  bus
);

`ifdef GLACC_SEQ_ET_EN
  localparam logic ET_ON = 1'b1;
`else
  localparam logic ET_ON = 1'b0;
`endif

  localparam int OUT_W = ROW_W + 1;
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b1, {ROW_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACC     = 3'd2,
    ROW_END = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t           state;
  logic             dense_q;
  logic [ROW_W-1:0] rows_q;
  logic [ACC_W-1:0] acc_last_q;
  logic [ACC_W-1:0] acc_cnt;
  logic [OUT_W-1:0] outstanding;

  logic             pd_live;
  logic             row_fire;
  logic [OUT_W-1:0] out_next;

  // Outstanding-row bookkeeping: a row end adds one, a pipe_done removes one.
  // Both in the same cycle cancel out. The count saturates at the top and floors at 0.
  always_comb begin
    pd_live  = bus.pipe_done && (state != IDLE);
    row_fire = (state == ROW_END) && !bus.stall;
    out_next = outstanding;
    if (row_fire && !pd_live) begin
      if (outstanding != OUT_MAX) out_next = outstanding + OUT_W'(1);
    end else if (!row_fire && pd_live) begin
      if (outstanding != '0) out_next = outstanding - OUT_W'(1);
    end
  end

  // Sequencer FSM with registered strobes. Pulse outputs default low each cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state                 <= IDLE;
      dense_q               <= 1'b0;
      rows_q                <= '0;
      acc_last_q            <= '0;
      acc_cnt               <= '0;
      outstanding           <= '0;
      bus.ROW_INDEX         <= '0;
      bus.RowIndex_Update   <= 1'b0;
      bus.BnkCtr_Clr        <= 1'b0;
      bus.BnkCtr_Latch      <= 1'b0;
      bus.GlbCtr_Latch      <= 1'b0;
      bus.MxPl_Sparse_Clr   <= 1'b0;
      bus.MxPl_Sparse_Latch <= 1'b0;
      bus.MxPl_Dense_Clr    <= 1'b0;
      bus.MxPl_Dense_Latch  <= 1'b0;
      bus.ET_L1_Clr         <= 1'b0;
      bus.ET_L1_En          <= 1'b0;
      bus.ET_L3_En          <= 1'b0;
      bus.ET_Thr_Latch      <= 1'b0;
      bus.ET_THRESHOLD      <= '0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
    end else begin
      bus.RowIndex_Update   <= 1'b0;
      bus.BnkCtr_Clr        <= 1'b0;
      bus.BnkCtr_Latch      <= 1'b0;
      bus.GlbCtr_Latch      <= 1'b0;
      bus.MxPl_Sparse_Clr   <= 1'b0;
      bus.MxPl_Sparse_Latch <= 1'b0;
      bus.MxPl_Dense_Clr    <= 1'b0;
      bus.MxPl_Dense_Latch  <= 1'b0;
      bus.ET_L1_Clr         <= 1'b0;
      bus.ET_L1_En          <= 1'b0;
      bus.ET_L3_En          <= 1'b0;
      bus.ET_Thr_Latch      <= 1'b0;
      bus.done              <= 1'b0;
      outstanding           <= out_next;

      case (state)
        IDLE: begin
          if (bus.start) begin
            dense_q               <= bus.cfg_dense;
            rows_q                <= bus.cfg_rows;
            // An accumulate length of 0 runs as a single cycle.
            acc_last_q            <= (bus.cfg_acc_len == '0) ? '0
                                     : bus.cfg_acc_len - ACC_W'(1);
            acc_cnt               <= '0;
            bus.BnkCtr_Clr        <= 1'b1;
            bus.MxPl_Dense_Clr    <= bus.cfg_dense;
            bus.MxPl_Sparse_Clr   <= !bus.cfg_dense;
            bus.ET_L1_Clr         <= ET_ON;
            bus.ET_Thr_Latch      <= ET_ON;
            bus.ET_THRESHOLD      <= ET_ON ? bus.cfg_et_thr : '0;
            bus.ROW_INDEX         <= '0;
            bus.RowIndex_Update   <= 1'b1;
            bus.busy              <= 1'b1;
            state                 <= SETUP;
          end
        end

        // SETUP's strobes are already on the wires. This edge is the first accumulate decision.
        SETUP, ACC: begin
          if (!bus.stall) begin
            bus.BnkCtr_Latch <= 1'b1;
            bus.ET_L1_En     <= ET_ON;
            if (acc_cnt == acc_last_q) begin
              acc_cnt <= '0;
              state   <= ROW_END;
            end else begin
              acc_cnt <= acc_cnt + ACC_W'(1);
              state   <= ACC;
            end
          end else begin
            state <= ACC;
          end
        end

        ROW_END: begin
          if (!bus.stall) begin
            bus.MxPl_Dense_Latch  <= dense_q;
            bus.MxPl_Sparse_Latch <= !dense_q;
            bus.GlbCtr_Latch      <= !dense_q;
            bus.ET_L3_En          <= ET_ON;
            bus.BnkCtr_Clr        <= 1'b1;
            if (bus.ROW_INDEX == rows_q) begin
              state <= DRAIN;
            end else begin
              bus.ROW_INDEX       <= bus.ROW_INDEX + ROW_W'(1);
              bus.RowIndex_Update <= 1'b1;
              state               <= ACC;
            end
          end
        end

        // Finish as soon as the count, including this cycle's pipe_done, reaches zero.
        DRAIN: begin
          if (out_next == '0) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Debug taps, both driven straight from registers.
  assign bus.state_dbg       = state;
  assign bus.outstanding_dbg = outstanding;

endmodule
